backoff_master: RTL and testbench
=================================

# backoff_master

Initiator side of `backoff_if`. It sits beside a coherency controller and turns a failed coherence attempt into a timed backoff request. It computes an exponentially growing backoff window, issues it to a `backoff_unit` slave, and cancels the wait through `interrupt` if a snoop event arrives first. It then reports either "retry now" or "aborted" back to the controller.

## Interface
- `BASE_BACKOFF`, 16: window for the first failure, in cycles.
- `MAX_EXP`, 10: maximum left-shift applied to `BASE_BACKOFF`.
- `MAX_BACKOFF`, 16'd10000: saturation cap on `backoff_value`.
- `ATTEMPT_W`, 8: width of the failed-attempt counter.
- `JITTER_W`, 4: jitter bits added when jitter is compiled in.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_fail`  in  1  pulse: the coherence attempt failed and a backoff is requested.
- `req_success`  in  1  pulse: the attempt succeeded; clears the attempt history.
- `snoop_event`  in  1  pulse: a coherence event that makes the pending backoff moot.
- `ready`  out  1  high when a `req_fail` pulse will be accepted.
- `retry_go`  out  1  one-cycle pulse: backoff elapsed, the controller may retry.
- `retry_abort`  out  1  one-cycle pulse: backoff was interrupted.
- `attempts`  out  ATTEMPT_W  current failed-attempt count.
- `backoff_value`  out  16  window delivered to the slave.
- `backoff_if_inst`  `backoff_if.master`  drives `valid` and `interrupt`, samples `ack`.

## Operation
- FSM states and outputs:
  - `S_IDLE`: `ready=1`.
  - `S_REQ`: `valid=1` for exactly one cycle.
  - `S_WAIT`: waiting on the slave.
  - `S_DONE`: `retry_go=1`.
  - `S_ABORT`: `retry_abort=1`.
- Transitions:
  - `S_IDLE` → `S_REQ` on `req_fail && !req_success`.
  - `S_REQ` → `S_WAIT` unconditionally.
  - `S_WAIT` → `S_DONE` on `ack`.
  - `S_WAIT` → `S_ABORT` on `snoop_event && !ack`.
  - `S_DONE` and `S_ABORT` → `S_IDLE`.
- Window computation:
  - Evaluated in 32 bits: `exp = BASE_BACKOFF << min(attempts, MAX_EXP)`.
  - `backoff_value = min(exp + jitter, MAX_BACKOFF)`, truncated to 16 bits.
  - The value is registered on the `S_IDLE`→`S_REQ` transition and held stable until the next accept.
- `attempts` update:
  - Increments on accept, saturating at `2^ATTEMPT_W-1`.
  - The window uses the pre-increment count, so the first failure gets `BASE_BACKOFF`.
  - Cleared in any state by `req_success`. `req_success` wins over a simultaneous `req_fail`, which is then not accepted.
- `interrupt = (state==S_WAIT) && snoop_event`, combinational. The slave only honours it in its backoff state.
- `ack` and `snoop_event` in the same `S_WAIT` cycle: `ack` wins and the FSM goes to `S_DONE`. The slave is already acking and ignores `interrupt`.
- `snoop_event` outside `S_WAIT` is ignored.
- `req_fail` while `ready=0` is dropped (no queueing). Controllers must check `ready`.
- `valid` is never held beyond one cycle. This prevents the slave re-arming after it acks.

## Timing
- Reset values:
  - state `S_IDLE`; `ready=1`.
  - `valid`, `interrupt`, `retry_go`, `retry_abort` all 0.
  - `attempts=0`, `backoff_value=0`.
- Accept at cycle t puts `valid` at t+1.
- With a `backoff_unit` slave, `ack` arrives at t+1+`backoff_value`+2.
- `retry_go` follows one cycle after `ack`. The total from `req_fail` to `retry_go` is `backoff_value`+4 cycles.
- Abort path: `snoop_event` at cycle s in `S_WAIT` gives `interrupt` at s and `retry_abort` at s+1.
- `ready` returns one cycle after `retry_go` or `retry_abort`.
- Reset mid-operation returns to reset values immediately (asynchronous). The system resets the slave in the same reset domain.

## Configuration
- `BACKOFF_MASTER_JITTER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; advances every cycle after reset) supplies `jitter = lfsr[JITTER_W-1:0]`.
  - This de-correlates contending cores.
- `BACKOFF_MASTER_JITTER_EN` undefined: `jitter = 0`, the LFSR is absent, and the windows are deterministic.

## Test plan
All scenarios use default parameters; scenarios 1–5 are run with jitter compiled out.
1. Reset, then one `req_fail` → `backoff_value=16`, `valid` pulses once, `retry_go` exactly 20 cycles after `req_fail`, `attempts=1`.
2. Four back-to-back failures, each after `retry_go` → windows 16, 32, 64, 128. `req_success` then gives `attempts=0` and a next window of 16.
3. `attempts` forced to 12 by 12 failures → window saturates at 10000 (16<<10 = 16384 is capped). The 12th window equals `MAX_BACKOFF`.
4. `snoop_event` 5 cycles into `S_WAIT` → `interrupt` high that cycle, `retry_abort` the next cycle, no `retry_go`, slave back in idle, `ready=1` two cycles later.
5. `snoop_event` coincident with `ack` → `retry_go` asserted, `retry_abort` not asserted. `req_fail` while busy is dropped and `attempts` is unchanged.
6. Jitter compiled in: 8 consecutive first-failure windows all lie in [16, 31] and are not all equal. Assert `rst` mid-`S_WAIT` → all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/backoff_if.sv
`default_nettype none
// ============================================================================
//  Module      : backoff_if
//  Description : Handshake between a backoff initiator and a backoff_unit.
//                valid starts a timed backoff, interrupt cancels it, ack
//                reports that the window has elapsed.
//  Revision    : 1.0  initial release
// ============================================================================
interface backoff_if;
    logic valid;
    logic interrupt;
    logic ack;

    modport master (output valid, output interrupt, input ack);
    modport slave  (input valid, input interrupt, output ack);
endinterface
`default_nettype wire

// File: rtl/backoff_master.sv
`default_nettype none
// ============================================================================
//  Module      : backoff_master
//  Description : Turns a failed coherence attempt into an exponentially
//                growing backoff request on backoff_if, cancels it on a snoop
//                event and reports retry/abort to the coherency controller.
//                Optional jitter: define BACKOFF_MASTER_JITTER_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module backoff_master #(
    parameter int unsigned BASE_BACKOFF = 16,
    parameter int unsigned MAX_EXP      = 10,
    parameter logic [15:0] MAX_BACKOFF  = 16'd10000,
    parameter int unsigned ATTEMPT_W    = 8,
    parameter int unsigned JITTER_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_fail,
    input  logic                 req_success,
    input  logic                 snoop_event,
    output logic                 ready,
    output logic                 retry_go,
    output logic                 retry_abort,
    output logic [ATTEMPT_W-1:0] attempts,
    output logic [15:0]          backoff_value,
    backoff_if.master            backoff_if_inst
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic                 retry_go_q, retry_go_d;
    logic                 retry_abort_q, retry_abort_d;
    logic [ATTEMPT_W-1:0] attempts_q, attempts_d;
    logic [15:0]          backoff_value_q, backoff_value_d;

    logic [JITTER_W-1:0]  jitter;
    logic [31:0]          win_shamt;
    logic [31:0]          win_exp;
    logic [31:0]          win_sum;
    logic [15:0]          win_value;

`ifdef BACKOFF_MASTER_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying jitter.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR register, seeded on reset, advancing every cycle afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign jitter = lfsr_q[JITTER_W-1:0];
`else
    assign jitter = '0;
`endif

    // Window for the current (pre-increment) attempt count, saturated at the cap.
    always_comb begin
        win_shamt = (32'(attempts_q) > MAX_EXP) ? MAX_EXP : 32'(attempts_q);
        win_exp   = BASE_BACKOFF << win_shamt;
        win_sum   = win_exp + 32'(jitter);
        win_value = (win_sum > 32'(MAX_BACKOFF)) ? MAX_BACKOFF : win_sum[15:0];
    end

    // Next-state, attempt history and registered-output decode.
    always_comb begin
        state_d         = state_q;
        attempts_d      = attempts_q;
        backoff_value_d = backoff_value_q;

        case (state_q)
            S_IDLE: begin
                if (req_fail && !req_success) begin
                    state_d         = S_REQ;
                    backoff_value_d = win_value;
                    if (attempts_q != {ATTEMPT_W{1'b1}}) begin
                        attempts_d = attempts_q + 1'b1;
                    end
                end
            end
            S_REQ:   state_d = S_WAIT;
            S_WAIT: begin
                // ack beats a same-cycle snoop: the slave has already finished.
                if (backoff_if_inst.ack) begin
                    state_d = S_DONE;
                end else if (snoop_event) begin
                    state_d = S_ABORT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Success wipes the history in any state, overriding an increment.
        if (req_success) begin
            attempts_d = '0;
        end

        ready_d       = (state_d == S_IDLE);
        valid_d       = (state_d == S_REQ);
        retry_go_d    = (state_d == S_DONE);
        retry_abort_d = (state_d == S_ABORT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ready_q         <= 1'b1;
            valid_q         <= 1'b0;
            retry_go_q      <= 1'b0;
            retry_abort_q   <= 1'b0;
            attempts_q      <= '0;
            backoff_value_q <= '0;
        end else begin
            state_q         <= state_d;
            ready_q         <= ready_d;
            valid_q         <= valid_d;
            retry_go_q      <= retry_go_d;
            retry_abort_q   <= retry_abort_d;
            attempts_q      <= attempts_d;
            backoff_value_q <= backoff_value_d;
        end
    end

    assign ready         = ready_q;
    assign retry_go      = retry_go_q;
    assign retry_abort   = retry_abort_q;
    assign attempts      = attempts_q;
    assign backoff_value = backoff_value_q;

    assign backoff_if_inst.valid     = valid_q;
    assign backoff_if_inst.interrupt = (state_q == S_WAIT) && snoop_event;

endmodule
`default_nettype wire

// File: tb/tb_backoff_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_backoff_master
//  Description : Self-checking bench for backoff_master with a behavioural
//                backoff_unit slave and a spec-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_backoff_master;

    localparam int unsigned BASE = 16;
    localparam int unsigned MAXE = 10;
    localparam int unsigned CAP  = 10000;
    localparam int unsigned ASAT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_fail;
    logic        req_success;
    logic        snoop_event;
    logic        ready;
    logic        retry_go;
    logic        retry_abort;
    logic [7:0]  attempts;
    logic [15:0] backoff_value;

    backoff_if bif ();

    backoff_master dut (
        .clk             (clk),
        .rst             (rst),
        .req_fail        (req_fail),
        .req_success     (req_success),
        .snoop_event     (snoop_event),
        .ready           (ready),
        .retry_go        (retry_go),
        .retry_abort     (retry_abort),
        .attempts        (attempts),
        .backoff_value   (backoff_value),
        .backoff_if_inst (bif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural backoff_unit: ack arrives backoff_value+2 cycles after valid;
    // interrupt is honoured only while still counting.
    logic        s_busy;
    int unsigned s_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_busy <= 1'b0;
            s_cnt  <= 0;
        end else if (!s_busy) begin
            if (bif.valid) begin
                s_busy <= 1'b1;
                s_cnt  <= backoff_value + 1;
            end
        end else if (s_cnt == 0) begin
            s_busy <= 1'b0;
        end else if (bif.interrupt) begin
            s_busy <= 1'b0;
        end else begin
            s_cnt <= s_cnt - 1;
        end
    end
    assign bif.ack = s_busy && (s_cnt == 0);

    int errors = 0;
    int checks = 0;
    int model_att = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned model_window(input int unsigned n);
        int unsigned e;
        longint      w;
        e = (n > MAXE) ? MAXE : n;
        w = longint'(BASE) << e;
        return (w > CAP) ? CAP : int'(w);
    endfunction

    task automatic do_success(input string tag);
        req_success = 1'b1;
        tick;
        req_success = 1'b0;
        model_att = 0;
        check({tag, ":att_clr"}, attempts, 0);
    endtask

    // mode 0: normal, 1: snoop k cycles into wait, 2: snoop with ack,
    // 3: normal plus a dropped req_fail while busy.
    task automatic run_fail(input string tag, input int mode, input int k, output int bv_obs);
        int t;
        int unsigned lo;
        int unsigned hi;
        bit seen;
        check({tag, ":ready"}, ready, 1);
        lo = model_window(model_att);
        hi = (lo + 15 > CAP) ? CAP : lo + 15;
        req_fail = 1'b1;
        t = cyc;
        tick;
        req_fail = 1'b0;
        check({tag, ":valid1"}, bif.valid, 1);
        bv_obs = int'(backoff_value);
`ifdef BACKOFF_MASTER_JITTER_EN
        check({tag, ":win_range"}, (bv_obs >= int'(lo) && bv_obs <= int'(hi)) ? 1 : 0, 1);
`else
        check({tag, ":window"}, bv_obs, lo);
        if (hi == 0) $display("unreachable");
`endif
        if (model_att < int'(ASAT)) model_att++;
        check({tag, ":attempts"}, attempts, model_att);
        tick;
        check({tag, ":valid0"}, bif.valid, 0);
        if (mode == 1) begin
            repeat (k) tick;
            snoop_event = 1'b1;
            #1;
            check({tag, ":interrupt"}, bif.interrupt, 1);
            tick;
            snoop_event = 1'b0;
            check({tag, ":abort"}, retry_abort, 1);
            check({tag, ":no_go"}, retry_go, 0);
            tick;
            check({tag, ":ready_ab"}, ready, 1);
            check({tag, ":slave_idle"}, s_busy, 0);
        end else if (mode == 2) begin
            seen = 1'b0;
            for (int i = 0; i < bv_obs + 10; i++) begin
                if (bif.ack) begin
                    seen = 1'b1;
                    break;
                end
                tick;
            end
            check({tag, ":ack_seen"}, seen, 1);
            snoop_event = 1'b1;
            tick;
            snoop_event = 1'b0;
            check({tag, ":go_win"}, retry_go, 1);
            check({tag, ":no_abort"}, retry_abort, 0);
            tick;
            check({tag, ":ready_go"}, ready, 1);
        end else begin
            if (mode == 3) begin
                tick;
                req_fail = 1'b1;
                tick;
                req_fail = 1'b0;
                check({tag, ":drop_att"}, attempts, model_att);
                check({tag, ":drop_valid"}, bif.valid, 0);
                check({tag, ":drop_bv"}, backoff_value, bv_obs);
            end
            seen = 1'b0;
            for (int i = 0; i < bv_obs + 20; i++) begin
                if (retry_go || retry_abort) begin
                    seen = 1'b1;
                    break;
                end
                tick;
            end
            check({tag, ":go"}, retry_go, 1);
            check({tag, ":abort0"}, retry_abort, 0);
            check({tag, ":latency"}, seen ? (cyc - t) : -1, bv_obs + 4);
            tick;
            check({tag, ":ready_go"}, ready, 1);
        end
    endtask

    initial begin
        int bv;
        int bmin;
        int bmax;
        int r;
        int unsigned lo;
        rst = 1'b1;
        req_fail = 1'b0;
        req_success = 1'b0;
        snoop_event = 1'b0;
        repeat (3) tick;
        check("rst:ready", ready, 1);
        check("rst:valid", bif.valid, 0);
        check("rst:interrupt", bif.interrupt, 0);
        check("rst:go", retry_go, 0);
        check("rst:abort", retry_abort, 0);
        check("rst:attempts", attempts, 0);
        check("rst:bv", backoff_value, 0);
        rst = 1'b0;
        tick;

        // 1: single failure
        run_fail("t1", 0, 0, bv);

        // 2: four consecutive failures, then success restarts the series
        do_success("t2");
        for (int n = 0; n < 4; n++) run_fail("t2", 0, 0, bv);
        do_success("t2b");
        run_fail("t2_after", 0, 0, bv);

        // success and fail together: fail is not accepted
        do_success("t2c");
        req_fail = 1'b1;
        req_success = 1'b1;
        tick;
        req_fail = 1'b0;
        req_success = 1'b0;
        check("both:valid", bif.valid, 0);
        check("both:attempts", attempts, 0);
        check("both:ready", ready, 1);

        // 3: twelve failures drive the window into saturation
        for (int n = 0; n < 12; n++) run_fail("t3", (n < 11) ? 1 : 0, 2, bv);
        check("t3:cap", bv, CAP);

        // 4: snoop five cycles into wait
        do_success("t4");
        run_fail("t4", 1, 5, bv);

        // 5: snoop coincident with ack; dropped request while busy
        run_fail("t5", 2, 0, bv);
        run_fail("t5_drop", 3, 0, bv);

        // 6: first-failure windows (jittered when compiled in)
        bmin = 32'h7fffffff;
        bmax = 0;
        for (int n = 0; n < 8; n++) begin
            do_success("t6");
            run_fail("t6", 0, 0, bv);
            if (bv < bmin) bmin = bv;
            if (bv > bmax) bmax = bv;
        end
`ifdef BACKOFF_MASTER_JITTER_EN
        check("t6:vary", (bmax != bmin) ? 1 : 0, 1);
`else
        check("t6:same", bmax - bmin, 0);
`endif

        // randomized mix
        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 9));
            if (model_att >= 5 || r < 2) begin
                do_success("rnd");
            end else if (r < 5) begin
                lo = model_window(model_att);
                run_fail("rnd_ab", 1, int'($urandom_range(0, lo)), bv);
            end else if (r < 6) begin
                run_fail("rnd_co", 2, 0, bv);
            end else begin
                run_fail("rnd_go", 0, 0, bv);
            end
        end

        // asynchronous reset mid-wait
        req_fail = 1'b1;
        tick;
        req_fail = 1'b0;
        tick;
        tick;
        #2;
        snoop_event = 1'b1;
        rst = 1'b1;
        #1;
        check("arst:ready", ready, 1);
        check("arst:valid", bif.valid, 0);
        check("arst:interrupt", bif.interrupt, 0);
        check("arst:go", retry_go, 0);
        check("arst:abort", retry_abort, 0);
        check("arst:attempts", attempts, 0);
        check("arst:bv", backoff_value, 0);
        snoop_event = 1'b0;
        model_att = 0;
        tick;
        rst = 1'b0;
        tick;
        run_fail("post_rst", 0, 0, bv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
